// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between decode and execute with a stall counter.
// Defining PIPE_STAGE_SKID_EN adds a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  // An empty stage must look like a NOP downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;
  logic              main_valid_n;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic [DATA_W-1:0] main_data_n;
  logic              skid_valid_n;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [DATA_W-1:0] skid_data_n;

  assign in_ready = ready_q;

  always_comb begin
    main_valid_n = main_valid;
    main_ctrl_n  = main_ctrl;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_ctrl_n  = skid_ctrl;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
    end else if (!main_valid || out_xfer) begin
      // Main frees up: the older skid entry goes first to keep order.
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_ctrl_n  = skid_ctrl;
        main_data_n  = skid_data;
        if (in_xfer) begin
          skid_ctrl_n = in_ctrl;
          skid_data_n = in_data;
        end else begin
          skid_valid_n = 1'b0;
        end
      end else if (in_xfer) begin
        main_valid_n = 1'b1;
        main_ctrl_n  = in_ctrl;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_n = 1'b1;
      skid_ctrl_n  = in_ctrl;
      skid_data_n  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      main_ctrl  <= main_ctrl_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_ctrl  <= skid_ctrl_n;
      skid_data  <= skid_data_n;
      ready_q    <= !skid_valid_n;
    end
  end
`else
  assign in_ready = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_ctrl  <= in_ctrl;
      main_data  <= in_data;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes accepted items into a FIFO model,
// an independent monitor compares every presented output against the model.
module tb_pipe_stage_reg;

  typedef struct {
    logic [7:0]   c;
    logic [110:0] d;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_ctrl = '0;
  logic [110:0] in_data = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_ctrl;
  logic [110:0] out_data;
  logic [15:0]  stall_cnt;

  item_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_stall = '0;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(111)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [110:0] rand_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[110:0];
  endfunction

  // One clock cycle of stimulus; acceptance follows the capacity rules, not the DUT.
  task automatic cycle(input bit iv, input logic [7:0] c, input logic [110:0] d,
                       input bit ordy, input bit fl, input bit r);
    bit exp_rdy;
    bit acc;
    @(negedge clk);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (sb.size() < 2);
`else
    exp_rdy = (sb.size() == 0) || ordy;
`endif
    if (mon_en) chk("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy && !fl && !r;
    #2;
    if (r || fl) sb.delete();
    else if (acc) sb.push_back('{c, d});
    if (r) mon_en = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0) begin
          chk("out_data", out_data, sb[0].d);
          chk("out_ctrl", out_ctrl, sb[0].c);
        end else begin
          chk("out_ctrl_bubble", out_ctrl, 0);
        end
        chk("stall_cnt", stall_cnt, exp_stall);
        if (rst) exp_stall = '0;
        else if (sb.size() > 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [110:0] a;
    logic [110:0] b;
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 1, 0, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_stall", stall_cnt, 0);

    // Streaming 1..4 at full throughput
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 111'(i), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("stream_stall", stall_cnt, 0);

    // Backpressure: A held for 3 cycles while B is offered
    a = rand_data();
    b = rand_data();
    cycle(1, 8'hA5, a, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h5B, b, 0, 0, 0);
    cycle(1, 8'h5B, b, 1, 0, 0);
    chk("bp_stall", stall_cnt, 3);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // Bubble after an all-ones control word
    cycle(1, 8'hFF, rand_data(), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("bubble_ctrl", out_ctrl, 8'h00);

    // Flush with the stage full and a new item C offered
    cycle(1, 8'h11, rand_data(), 0, 0, 0);
    cycle(1, 8'h22, rand_data(), 0, 0, 0);
    cycle(1, 8'hCC, rand_data(), 0, 1, 0);
    cycle(0, '0, '0, 1, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_ready", in_ready, 1);
    cycle(0, '0, '0, 1, 0, 0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), rand_data(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) == 0);
    end

    // Counter saturation, then reset mid-stall
    cycle(0, '0, '0, 1, 0, 1);
    cycle(1, 8'h77, rand_data(), 1, 0, 0);
    for (int i = 0; i < 65540; i++) cycle(0, '0, '0, 0, 0, 0);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    cycle(1, 8'h33, rand_data(), 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    cycle(0, '0, '0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
